// File: rtl/vending_param.sv
// Parametrised vending FSM: accepts N/D/Q coins, vends at PRICE, returns the
// excess as UNIT-valued change pulses, and supports cancel/refund.
module vending_param #(
    parameter int unsigned PRICE    = 30,
    parameter int unsigned V_N      = 5,
    parameter int unsigned V_D      = 10,
    parameter int unsigned V_Q      = 25,
    parameter int unsigned UNIT     = 5,
    parameter int unsigned CREDIT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                N,
    input  logic                D,
    input  logic                Q,
    input  logic                cancel,
    output logic                candy,
    output logic                change,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(UNIT);
    localparam logic [CREDIT_W-1:0] VN_C    = CREDIT_W'(V_N);
    localparam logic [CREDIT_W-1:0] VD_C    = CREDIT_W'(V_D);
    localparam logic [CREDIT_W-1:0] VQ_C    = CREDIT_W'(V_Q);

    typedef enum logic [1:0] {
        ACCEPT  = 2'd0,
        VEND    = 2'd1,
        CHG_ON  = 2'd2,
        CHG_OFF = 2'd3
    } state_t;

    state_t                state_q;
    logic [CREDIT_W-1:0]   credit_q;
    logic                  candy_q;
    logic                  change_q;
    logic                  coin_reject_q;
    logic [CREDIT_W-1:0]   sum_c;
    logic                  any_coin_c;

    // Credit plus every coin presented this cycle; sized so it cannot wrap.
    always_comb begin
        sum_c = credit_q
              + (N ? VN_C : '0)
              + (D ? VD_C : '0)
              + (Q ? VQ_C : '0);
        any_coin_c = N | D | Q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= ACCEPT;
            credit_q      <= '0;
            candy_q       <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            candy_q       <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= (state_q != ACCEPT) && any_coin_c;
            case (state_q)
                ACCEPT: begin
                    // Cancel takes priority over a vend completed in the same cycle.
                    if (cancel && (sum_c != '0)) begin
                        credit_q <= sum_c;
                        state_q  <= CHG_OFF;
                    end else if (sum_c >= PRICE_C) begin
                        credit_q <= sum_c - PRICE_C;
                        candy_q  <= 1'b1;
                        state_q  <= VEND;
                    end else begin
                        credit_q <= sum_c;
                    end
                end
                VEND: begin
                    if (credit_q >= UNIT_C) begin
                        change_q <= 1'b1;
                        credit_q <= credit_q - UNIT_C;
                        state_q  <= CHG_ON;
                    end else begin
                        state_q  <= ACCEPT;
                    end
                end
                CHG_ON: begin
                    state_q <= CHG_OFF;
                end
                CHG_OFF: begin
                    if (credit_q != '0) begin
                        change_q <= 1'b1;
                        credit_q <= credit_q - UNIT_C;
                        state_q  <= CHG_ON;
                    end else begin
                        state_q  <= ACCEPT;
                    end
                end
                default: state_q <= ACCEPT;
            endcase
        end
    end

    assign candy       = candy_q;
    assign change      = change_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign busy        = (state_q != ACCEPT);

endmodule

// File: tb/tb_vending_param.sv
// Directed bench for vending_param: candy/change pulses are scoreboarded
// against expected events queued when each stimulus step is driven.
module tb_vending_param;

    localparam int unsigned CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          N, D, Q, cancel;
    logic          candy, change, busy, coin_reject;
    logic [CW-1:0] credit;

    typedef struct {
        bit is_change;
        int cr;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  rej_cnt  = 0;

    vending_param #(
        .PRICE(30), .V_N(5), .V_D(10), .V_Q(25), .UNIT(5), .CREDIT_W(CW)
    ) dut (
        .clock(clock), .reset(reset), .N(N), .D(D), .Q(Q), .cancel(cancel),
        .candy(candy), .change(change), .credit(credit), .busy(busy),
        .coin_reject(coin_reject)
    );

    always #5 clock = ~clock;

    // Monitor: record every vend / change cycle with the credit shown then.
    always begin
        @(posedge clock);
        #1;
        if (candy)       obs_q.push_back('{is_change: 1'b0, cr: int'(credit)});
        if (change)      obs_q.push_back('{is_change: 1'b1, cr: int'(credit)});
        if (coin_reject) rej_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic n, input logic d, input logic q);
        N = n; D = d; Q = q;
        tick();
        N = 1'b0; D = 1'b0; Q = 1'b0;
    endtask

    task automatic push_exp(input bit is_chg, input int cr);
        exp_q.push_back('{is_change: is_chg, cr: cr});
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_idle_timeout"}, int'(busy), 0);
        repeat (3) tick();
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_event_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_ev%0d_kind", tag, i), int'(obs_q[i].is_change), int'(exp_q[i].is_change));
            check($sformatf("%s_ev%0d_credit", tag, i), obs_q[i].cr, exp_q[i].cr);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int rej0;
        N = 1'b0; D = 1'b0; Q = 1'b0; cancel = 1'b0;
        reset = 1'b0;
        tick(); tick();
        check("rst_credit", int'(credit), 0);
        check("rst_candy", int'(candy), 0);
        check("rst_change", int'(change), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_reject", int'(coin_reject), 0);
        reset = 1'b1;
        obs_q.delete();

        // 30 cents exact: D, D, D
        push_exp(1'b0, 0);
        coin(0, 1, 0);
        check("t30_credit10", int'(credit), 10);
        coin(0, 1, 0);
        check("t30_credit20", int'(credit), 20);
        coin(0, 1, 0);
        check("t30_candy", int'(candy), 1);
        check("t30_credit0", int'(credit), 0);
        check("t30_busy", int'(busy), 1);
        tick();
        check("t30_candy_off", int'(candy), 0);
        check("t30_busy_off", int'(busy), 0);
        wait_idle("t30");
        compare_events("t30");

        // 35 cents: D, Q -> one change pulse
        push_exp(1'b0, 5);
        push_exp(1'b1, 0);
        coin(0, 1, 0);
        coin(0, 0, 1);
        check("t35_candy_credit", int'(credit), 5);
        tick();
        check("t35_first_change", int'(change), 1);
        wait_idle("t35");
        check("t35_final_credit", int'(credit), 0);
        compare_events("t35");

        // 40 cents: N, idle, N, idle, N, idle, Q -> two change pulses
        push_exp(1'b0, 10);
        push_exp(1'b1, 5);
        push_exp(1'b1, 0);
        coin(1, 0, 0); check("t40_step5", int'(credit), 5); tick();
        coin(1, 0, 0); check("t40_step10", int'(credit), 10); tick();
        coin(1, 0, 0); check("t40_step15", int'(credit), 15); tick();
        coin(0, 0, 1);
        wait_idle("t40");
        compare_events("t40");

        // Simultaneous coins to 65, then a rejected Q mid-train
        push_exp(1'b0, 35);
        for (int c = 30; c >= 0; c -= 5) push_exp(1'b1, c);
        coin(0, 0, 1);
        check("tsim_credit25", int'(credit), 25);
        coin(1, 1, 1);
        check("tsim_candy", int'(candy), 1);
        check("tsim_credit35", int'(credit), 35);
        tick(); tick();
        rej0 = rej_cnt;
        coin(0, 0, 1);
        check("tsim_reject_pulse", int'(coin_reject), 1);
        tick();
        check("tsim_reject_off", int'(coin_reject), 0);
        wait_idle("tsim");
        check("tsim_reject_count", rej_cnt - rej0, 1);
        check("tsim_final_credit", int'(credit), 0);
        compare_events("tsim");

        // Cancel after N, D -> refund of 15 as three pulses, no candy
        push_exp(1'b1, 10);
        push_exp(1'b1, 5);
        push_exp(1'b1, 0);
        coin(1, 0, 0);
        coin(0, 1, 0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("tcan_credit15", int'(credit), 15);
        check("tcan_busy", int'(busy), 1);
        check("tcan_no_candy", int'(candy), 0);
        tick();
        check("tcan_first_change", int'(change), 1);
        wait_idle("tcan");
        compare_events("tcan");

        // Cancel with zero credit is ignored
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("tcan0_busy", int'(busy), 0);
        check("tcan0_credit", int'(credit), 0);
        repeat (4) tick();
        compare_events("tcan0");

        // Reset mid-change: Q, Q -> candy at 20, first pulse, then reset
        push_exp(1'b0, 20);
        push_exp(1'b1, 15);
        coin(0, 0, 1);
        coin(0, 0, 1);
        check("trst_candy_credit", int'(credit), 20);
        tick();
        check("trst_first_change", int'(change), 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("trst_credit", int'(credit), 0);
        check("trst_change", int'(change), 0);
        check("trst_busy", int'(busy), 0);
        repeat (10) tick();
        compare_events("trst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vending_param.md
Name: vending_param

Overview:
- Parametrised successor to the fixed-price candy vending FSM.
- Accepts nickel, dime and quarter pulses, including simultaneous coins. Coin values and price are parameters.
- Vends one item once credit reaches PRICE, then returns the excess as a train of counted change pulses.
- Adds cancel/refund, a visible credit count, a busy flag, and rejection of coins inserted while busy.

Parameters:
- PRICE, 30: item price in cents; must be a multiple of UNIT.
- V_N, 5: nickel value in cents.
- V_D, 10: dime value in cents.
- V_Q, 25: quarter value in cents.
- UNIT, 5: value of one change pulse in cents; V_N, V_D, V_Q and PRICE must all be multiples of it.
- CREDIT_W, 8: credit register width; must hold PRICE-UNIT+V_N+V_D+V_Q (default max 65).

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset.
- N  in  1  nickel inserted; each high cycle counts as one coin.
- D  in  1  dime inserted; each high cycle counts as one coin.
- Q  in  1  quarter inserted; each high cycle counts as one coin.
- cancel  in  1  request a refund of all current credit.
- candy  out  1  one-cycle vend pulse.
- change  out  1  one pulse per UNIT of change returned.
- credit  out  CREDIT_W  current credit in cents.
- busy  out  1  high whenever state != ACCEPT.
- coin_reject  out  1  one-cycle pulse flagging coins ignored while busy.

Behaviour:
- Reset: on any edge with reset==0:
  - state<=ACCEPT.
  - credit, candy, change, coin_reject <= 0.
  - Any pending change is forfeited. Applies mid-vend and mid-change.
- Sum: sum = credit + N*V_N + D*V_D + Q*V_Q, computed at CREDIT_W bits. It cannot overflow given the CREDIT_W rule above.
- States: ACCEPT, VEND, CHG_ON, CHG_OFF. All outputs are registered.
- ACCEPT, priority order:
  - 1) cancel==1 and sum>0: credit<=sum, state<=CHG_OFF, no candy. Cancel beats vend even when sum>=PRICE.
  - 2) sum>=PRICE: credit<=sum-PRICE, candy<=1, state<=VEND.
  - 3) otherwise credit<=sum. Cancel with sum==0 is ignored.
- VEND: candy<=0 at the next edge.
  - If credit>=UNIT: change<=1, credit<=credit-UNIT, state<=CHG_ON.
  - Else state<=ACCEPT.
- CHG_ON: change<=0, state<=CHG_OFF.
- CHG_OFF:
  - If credit>0: change<=1, credit<=credit-UNIT, state<=CHG_ON.
  - Else state<=ACCEPT.
- Change waveform: change is high 1 cycle, low at least 1 cycle per UNIT. Total pulses = excess/UNIT.
- Latency:
  - candy rises at the edge that samples the completing coin(s).
  - The first change pulse follows one cycle after candy.
  - After a cancel, the first change pulse comes one cycle after the cancel edge.
- Busy coins: any of N/D/Q high while state!=ACCEPT:
  - Coins are not credited.
  - coin_reject<=1 for that cycle's following clock period.
  - Otherwise coin_reject<=0.
- cancel is ignored outside ACCEPT.
- busy is a combinational decode of state (state!=ACCEPT).
- Only one item is vended per entry to VEND. Excess credit is always refunded, never carried to a second vend.

Test Plan:
- 30 cents exact: reset low 2 cycles, then D,D,D on consecutive cycles -> candy high exactly 1 cycle after the 3rd D edge; zero change pulses; credit returns to 0; busy low 1 cycle later.
- 35 cents: D then Q on consecutive cycles -> candy 1 cycle with credit=5; then exactly 1 change pulse; final credit=0, state ACCEPT.
- 40 cents: N, idle, N, idle, N, idle, Q -> credit steps 5,10,15 before the Q; candy pulses once; exactly 2 separated change pulses.
- Simultaneous coins: Q, then N=D=Q=1 in one cycle -> credit 25 then sum 65, so candy pulses with credit=35 and 7 change pulses follow. A Q inserted during the change train -> coin_reject 1 cycle, credit unchanged, still 7 pulses.
- Cancel: N, D, then cancel -> no candy; 3 change pulses; credit 15->0. A separate case, cancel with zero credit -> no activity.
- Reset mid-change: 50 cents (Q,Q) -> after the first change pulse, reset low 1 cycle -> credit=0, change=0, busy=0; no further pulses.
